// File: rtl/uart_rx_os_if.sv
// Serial line and delivered-word bundle for the oversampling UART receiver.
// The receiver side uses the master modport; the line driver / consumer side uses slave.
interface uart_rx_os_if #(
    parameter int DATA_BITS = 8
);
    logic                 UART_RX;
    logic                 data_valid;
    logic [DATA_BITS-1:0] UART_DATA;
    logic [DATA_BITS-1:0] pre_UART_DATA;
    logic                 frame_err;
    logic                 parity_err;

    modport master (
        input  UART_RX,
        output data_valid, UART_DATA, pre_UART_DATA, frame_err, parity_err
    );

    modport slave (
        output UART_RX,
        input  data_valid, UART_DATA, pre_UART_DATA, frame_err, parity_err
    );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: mid-bit sampling, framing error and break handling.
// Define UART_RX_PARITY_EN to compile in the parity bit and a live parity_err.
module uart_rx_os #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_os_if.master   bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    // Expected parity bit for a received word.
    function automatic logic parity_expect(input logic [DATA_BITS-1:0] d);
        return (^d) ^ PARITY_ODD;
    endfunction

    state_t               state_r, state_nxt_s;
    logic [1:0]           sync_r;
    logic                 rxs_s;
    logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;
    logic [BIT_W-1:0]     bit_r, bit_nxt_s;
    logic [DATA_BITS-1:0] shift_r, shift_nxt_s;
    logic [DATA_BITS-1:0] data_r, data_nxt_s, pre_r, pre_nxt_s;
    logic                 data_valid_r, data_valid_nxt_s;
    logic                 frame_err_r, frame_err_nxt_s;
    logic                 parity_err_r, parity_err_nxt_s;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_r, par_bad_nxt_s;
`endif

    assign rxs_s = sync_r[1];

    // Two-flop synchronizer on the asynchronous serial line, idling high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], bus.UART_RX};
        end
    end

    // State, bit-timing counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            bit_r        <= '0;
            shift_r      <= '0;
            data_r       <= '0;
            pre_r        <= '0;
            data_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_r    <= 1'b0;
`endif
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            bit_r        <= bit_nxt_s;
            shift_r      <= shift_nxt_s;
            data_r       <= data_nxt_s;
            pre_r        <= pre_nxt_s;
            data_valid_r <= data_valid_nxt_s;
            frame_err_r  <= frame_err_nxt_s;
            parity_err_r <= parity_err_nxt_s;
`ifdef UART_RX_PARITY_EN
            par_bad_r    <= par_bad_nxt_s;
`endif
        end
    end

    // Next-state and next-output logic; the counter restarts at every sample point.
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r + CNT_W'(1);
        bit_nxt_s        = bit_r;
        shift_nxt_s      = shift_r;
        data_nxt_s       = data_r;
        pre_nxt_s        = pre_r;
        data_valid_nxt_s = 1'b0;
        frame_err_nxt_s  = 1'b0;
        parity_err_nxt_s = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_nxt_s    = par_bad_r;
`endif
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = '0;
                if (!rxs_s) begin
                    state_nxt_s = ST_START;
                    bit_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == HALF_M1) begin
                    cnt_nxt_s   = '0;
                    state_nxt_s = rxs_s ? ST_IDLE : ST_DATA;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (cnt_r == FULL_M1) begin
                    cnt_nxt_s   = '0;
                    shift_nxt_s = {rxs_s, shift_r[DATA_BITS-1:1]};
                    if (bit_r == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt_s = ST_PARITY;
`else
                        state_nxt_s = ST_STOP;
`endif
                    end else begin
                        bit_nxt_s = bit_r + BIT_W'(1);
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_r == FULL_M1) begin
                    cnt_nxt_s     = '0;
                    par_bad_nxt_s = (rxs_s != parity_expect(shift_r));
                    state_nxt_s   = ST_STOP;
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_r == FULL_M1) begin
                    cnt_nxt_s = '0;
                    if (rxs_s) begin
                        pre_nxt_s        = data_r;
                        data_nxt_s       = shift_r;
                        data_valid_nxt_s = 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err_nxt_s = par_bad_r;
`endif
                        state_nxt_s      = ST_IDLE;
                    end else begin
                        frame_err_nxt_s = 1'b1;
                        state_nxt_s     = ST_BREAK;
                    end
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            // Held-low line: one frame_err already reported, wait for idle.
            ST_BREAK: begin
                cnt_nxt_s = '0;
                if (rxs_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BREAK;
                end
            end
            default: begin
                cnt_nxt_s   = '0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign bus.data_valid    = data_valid_r;
    assign bus.UART_DATA     = data_r;
    assign bus.pre_UART_DATA = pre_r;
    assign bus.frame_err     = frame_err_r;
    assign bus.parity_err    = parity_err_r;
endmodule
